// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron unit: FSM states, width helpers
// and the saturating add used by the weight update.
package perceptron_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // Address width covering weight indices 0..n-1 plus the bias slot n.
   function automatic int unsigned addr_width(input int unsigned n_inputs);
      return (n_inputs < 1) ? 1 : $clog2(n_inputs + 1);
   endfunction

   // Smallest accumulator that cannot overflow: bias plus n weights.
   function automatic int unsigned min_acc_width(input int unsigned w_width,
                                                 input int unsigned n_inputs);
      return w_width + $clog2(n_inputs + 1);
   endfunction

   // Signed add clamped to the range of a w_width-bit two's complement value.
   function automatic longint sat_add(input longint a, input longint b,
                                      input int unsigned w_width);
      longint sum;
      longint hi;
      longint lo;
      sum = a + b;
      hi  = (longint'(1) <<< (w_width - 1)) - 1;
      lo  = -hi - 1;
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
   endfunction

endpackage

// File: rtl/perceptron_weight_bank.sv
// N weights plus bias in one register array (slot N is the bias), with a
// config write port, an indexed read, and a parallel saturating training update.
module perceptron_weight_bank
   import perceptron_pkg::*;
#(
   parameter int unsigned N_INPUTS = 2,
   parameter int unsigned W_WIDTH  = 8,
   parameter int unsigned LR_SHIFT = 0,
   parameter int unsigned AW       = addr_width(N_INPUTS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [AW-1:0]              cfg_addr,
   input  logic signed [W_WIDTH-1:0]  cfg_wdata,
   input  logic [AW-1:0]              rd_idx,
   output logic signed [W_WIDTH-1:0]  rd_w_c,
   output logic signed [W_WIDTH-1:0]  bias_c,
   input  logic                       upd_en,
   input  logic                       upd_dec,
   input  logic [N_INPUTS-1:0]        upd_x
);

   localparam longint STEP = longint'(1) <<< LR_SHIFT;

   logic signed [W_WIDTH-1:0] w_q [N_INPUTS+1];
   logic signed [W_WIDTH-1:0] w_d [N_INPUTS+1];
   longint                    delta;

   // Config writes only occur in IDLE and updates only in UPDATE, so they never collide.
   always_comb begin
      w_d   = w_q;
      delta = upd_dec ? -STEP : STEP;
      if (cfg_we) begin
         if (32'(cfg_addr) <= N_INPUTS) begin
            w_d[cfg_addr] = cfg_wdata;
         end
      end else if (upd_en) begin
         for (int i = 0; i < N_INPUTS; i++) begin
            if (upd_x[i]) begin
               w_d[i] = W_WIDTH'(sat_add(longint'(w_q[i]), delta, W_WIDTH));
            end
         end
         w_d[N_INPUTS] = W_WIDTH'(sat_add(longint'(w_q[N_INPUTS]), delta, W_WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= N_INPUTS; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         w_q <= w_d;
      end
   end

   assign rd_w_c = w_q[rd_idx];
   assign bias_c = w_q[N_INPUTS];

endmodule

// File: rtl/perceptron_unit.sv
// Sequential single-neuron perceptron: one weight per cycle into a signed
// accumulator, hard threshold at zero, optional perceptron-rule training.
module perceptron_unit
   import perceptron_pkg::*;
#(
   parameter int unsigned N_INPUTS  = 2,
   parameter int unsigned W_WIDTH   = 8,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned LR_SHIFT  = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [N_INPUTS-1:0]                in_x,
   input  logic                               in_train,
   input  logic                               in_target,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_y,
   output logic signed [ACC_WIDTH-1:0]        out_act,
   input  logic                               cfg_we,
   input  logic [addr_width(N_INPUTS)-1:0]    cfg_addr,
   input  logic signed [W_WIDTH-1:0]          cfg_wdata,
   output logic                               cfg_ready
);

   localparam int unsigned   AW       = addr_width(N_INPUTS);
   localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);

   if (N_INPUTS < 1) begin : g_chk_n
      $error("perceptron_unit: N_INPUTS must be at least 1");
   end
   if (ACC_WIDTH < min_acc_width(W_WIDTH, N_INPUTS)) begin : g_chk_acc
      $error("perceptron_unit: ACC_WIDTH too narrow for W_WIDTH and N_INPUTS");
   end

   state_e                       state_q,     state_d;
   logic [AW-1:0]                idx_q,       idx_d;
   logic signed [ACC_WIDTH-1:0]  acc_q,       acc_d;
   logic [N_INPUTS-1:0]          x_q,         x_d;
   logic                         train_q,     train_d;
   logic                         target_q,    target_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_y_q,     out_y_d;
   logic signed [ACC_WIDTH-1:0]  out_act_q,   out_act_d;

   logic signed [W_WIDTH-1:0]    rd_w_c;
   logic signed [W_WIDTH-1:0]    bias_c;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic                         x_bit;
   logic                         idle;
   logic                         pred_y;
   logic                         upd_en;

   assign idle      = (state_q == ST_IDLE);
   assign cfg_ready = idle;
   assign in_ready  = idle && !cfg_we;
   assign pred_y    = !acc_q[ACC_WIDTH-1];
   assign upd_en    = (state_q == ST_UPDATE) && (target_q != pred_y);

   perceptron_weight_bank #(
      .N_INPUTS (N_INPUTS),
      .W_WIDTH  (W_WIDTH),
      .LR_SHIFT (LR_SHIFT),
      .AW       (AW)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we && idle),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .rd_idx    (idx_q),
      .rd_w_c    (rd_w_c),
      .bias_c    (bias_c),
      .upd_en    (upd_en),
      .upd_dec   (!target_q),
      .upd_x     (x_q)
   );

   // Current term: the indexed weight gated by its feature bit.
   always_comb begin
      x_bit = 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (idx_q == AW'(i)) x_bit = x_q[i];
      end
      acc_sum = acc_q + (x_bit ? ACC_WIDTH'(rd_w_c) : {ACC_WIDTH{1'b0}});
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      x_d         = x_q;
      train_d     = train_q;
      target_d    = target_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_act_d   = out_act_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && !cfg_we) begin
               x_d      = in_x;
               train_d  = in_train;
               target_d = in_target;
               acc_d    = ACC_WIDTH'(bias_c);
               idx_d    = '0;
               state_d  = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            acc_d = acc_sum;
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               if (train_q) begin
                  state_d = ST_UPDATE;
               end else begin
                  state_d     = ST_RESP;
                  out_valid_d = 1'b1;
                  out_y_d     = !acc_sum[ACC_WIDTH-1];
                  out_act_d   = acc_sum;
               end
            end
         end
         // Response reports the prediction made before the weights move.
         ST_UPDATE: begin
            state_d     = ST_RESP;
            out_valid_d = 1'b1;
            out_y_d     = pred_y;
            out_act_d   = acc_q;
         end
         ST_RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         x_q         <= '0;
         train_q     <= 1'b0;
         target_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= 1'b0;
         out_act_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         train_q     <= train_d;
         target_q    <= target_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_act_q   <= out_act_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_act   = out_act_q;

endmodule

// File: tb/tb_perceptron_unit.sv
// Scoreboard bench for perceptron_unit (N=4): directed test-plan cases plus
// random traffic against an arithmetic reference model of the neuron.
module tb_perceptron_unit;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 8;
   localparam int unsigned ACC = 16;
   localparam int unsigned LR  = 0;
   localparam int unsigned AW  = 3;
   localparam int          WMAX = (1 << (W - 1)) - 1;
   localparam int          WMIN = -(1 << (W - 1));

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [N-1:0]          in_x = '0;
   logic                  in_train = 1'b0;
   logic                  in_target = 1'b0;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic                  out_y;
   logic signed [ACC-1:0] out_act;
   logic                  cfg_we = 1'b0;
   logic [AW-1:0]         cfg_addr = '0;
   logic signed [W-1:0]   cfg_wdata = '0;
   logic                  cfg_ready;

   always #5 clk = ~clk;

   perceptron_unit #(
      .N_INPUTS  (N),
      .W_WIDTH   (W),
      .ACC_WIDTH (ACC),
      .LR_SHIFT  (LR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_train  (in_train),
      .in_target (in_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_act   (out_act),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_ready (cfg_ready)
   );

   typedef struct {
      logic y;
      int   act;
      int   valid_cycle;
   } exp_t;

   exp_t sb[$];
   int   w_m [N+1];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic hold_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int clamp(input int v);
      if (v > WMAX) return WMAX;
      if (v < WMIN) return WMIN;
      return v;
   endfunction

   // Reference neuron: dot product plus bias, threshold, then perceptron rule.
   task automatic model_sample(input logic [N-1:0] x, input logic tr, input logic tg,
                               output exp_t e);
      int act;
      int step;
      act = w_m[N];
      for (int i = 0; i < N; i++) if (x[i]) act += w_m[i];
      e.y           = (act >= 0);
      e.act         = act;
      e.valid_cycle = cyc + N + (tr ? 1 : 0);
      if (tr && (tg != e.y)) begin
         step = (tg ? 1 : -1) * (1 << LR);
         for (int i = 0; i < N; i++) if (x[i]) w_m[i] = clamp(w_m[i] + step);
         w_m[N] = clamp(w_m[N] + step);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i <= N; i++) w_m[i] = 0;
      sb.delete();
   endtask

   // out_ready: random unless the bench is forcing backpressure.
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: latency on each out_valid rise, payload on each handshake.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               if (sb.size() == 0) check("spurious_out_valid", 1, 0);
               else check("latency_cycle", cyc, sb[0].valid_cycle);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check("out_y", out_y, e.y);
               check("out_act", out_act, e.act);
            end
            prev_valid = out_valid;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cfg_write(input int addr, input int data);
      bit ok;
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = W'(data);
      ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (cfg_ready) begin ok = 1; break; end
      end
      if (!ok) check("cfg_ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (ok && addr <= N) w_m[addr] = data;
      cfg_we = 1'b0;
   endtask

   task automatic send_sample(input logic [N-1:0] x, input logic tr, input logic tg);
      bit   ok;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; in_x = x; in_train = tr; in_target = tg;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (ok) begin
         model_sample(x, tr, tg, e);
         sb.push_back(e);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
      end
      if (!ok) check("drain_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values.
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_act", out_act, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_cfg_ready", cfg_ready, 1);
      send_sample(4'b1111, 0, 0);
      wait_drain();

      // OR gate on x[1:0].
      cfg_write(0, 10); cfg_write(1, 10); cfg_write(4, -10);
      send_sample(4'b0000, 0, 0);
      send_sample(4'b0001, 0, 0);
      send_sample(4'b0011, 0, 0);
      wait_drain();

      // NAND gate on x[1:0].
      cfg_write(0, -10); cfg_write(1, -10); cfg_write(4, 10);
      send_sample(4'b0011, 0, 0);
      send_sample(4'b0010, 0, 0);
      wait_drain();

      // Training from reset moves the bias down by one.
      do_reset();
      send_sample(4'b0000, 1, 0);
      send_sample(4'b0000, 0, 0);
      wait_drain();

      // Saturation of a weight already at the positive limit.
      do_reset();
      cfg_write(0, 127); cfg_write(4, -128);
      send_sample(4'b0001, 1, 1);
      send_sample(4'b0001, 0, 0);
      wait_drain();

      // Backpressure: response held stable, input and config blocked.
      hold_ready = 1'b1;
      send_sample(4'b0011, 0, 0);
      for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
      check("bp_valid_seen", out_valid, 1);
      if (sb.size() != 0) begin
         e = sb[0];
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_y", out_y, e.y);
            check("bp_out_act", out_act, e.act);
            check("bp_in_ready", in_ready, 0);
            check("bp_cfg_ready", cfg_ready, 0);
         end
      end
      hold_ready = 1'b0;
      wait_drain();

      // Config has priority over a simultaneous sample.
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = AW'(2); cfg_wdata = W'(-20);
      in_valid = 1'b1; in_x = 4'b0100; in_train = 1'b0; in_target = 1'b0;
      @(negedge clk);
      check("prio_in_ready", in_ready, 0);
      check("prio_cfg_ready", cfg_ready, 1);
      @(posedge clk); #1;
      w_m[2] = -20;
      cfg_we = 1'b0;
      @(negedge clk);
      check("prio_in_ready_next", in_ready, 1);
      @(posedge clk); #1;
      model_sample(4'b0100, 0, 0, e);
      sb.push_back(e);
      in_valid = 1'b0;
      wait_drain();

      // Random traffic including out-of-range config addresses.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            int d;
            if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1) ? WMAX : WMIN;
            else d = int'($urandom_range(0, 255)) - 128;
            cfg_write(int'($urandom_range(0, 7)), d);
         end else begin
            send_sample(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
         end
      end
      wait_drain();

      // Reset partway through accumulation clears weights too.
      cfg_write(0, 5); cfg_write(1, 6); cfg_write(2, 7); cfg_write(3, 8); cfg_write(4, 3);
      hold_ready = 1'b1;
      send_sample(4'b1111, 0, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      hold_ready = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_cfg_ready", cfg_ready, 1);
      check("midrst_out_act", out_act, 0);
      send_sample(4'b1111, 0, 0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
